// File: rtl/uart_pkg.sv
// Shared UART receive-side definitions: default data width and entry-word layout.
// Entry word = {framing_error, parity_error, data}.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int PAR_ERR_BIT        = DEFAULT_DATA_WIDTH;
  localparam int FRM_ERR_BIT        = DEFAULT_DATA_WIDTH + 1;
  localparam int ENTRY_WIDTH        = DEFAULT_DATA_WIDTH + 2;

  // Layout helpers for instances built with a non-default data width.
  function automatic int par_err_bit(input int data_width);
    return data_width;
  endfunction

  function automatic int frm_err_bit(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int entry_width(input int data_width);
    return data_width + 2;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read, no reset.
// Latency: write lands on the clock edge, read is combinational; no backpressure.
module uart_fifo_mem #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int WIDTH      = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_dat,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_dat
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// FWFT receive FIFO behind UART_RX: one push per data_valid rising edge, sticky overflow.
// Latency: a push is visible right after its edge; when full, a push without a same-cycle pop is dropped.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_WIDTH-1:0]         P_DATA,
  input  logic                          data_valid,
  input  logic                          parity_error,
  input  logic                          framing_error,
  input  logic                          RD_EN,
  input  logic                          CLR_OVF,
  output logic [DATA_WIDTH-1:0]         RD_DATA,
  output logic                          RD_PAR_ERR,
  output logic                          RD_FRM_ERR,
  output logic                          EMPTY,
  output logic                          FULL,
  output logic [$clog2(DEPTH):0]        COUNT,
  output logic                          OVERFLOW
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int EW         = entry_width(DATA_WIDTH);
  localparam int PAR_BIT    = par_err_bit(DATA_WIDTH);
  localparam int FRM_BIT    = frm_err_bit(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  generate
    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_fifo: DEPTH must be a power of two between 2 and 64");
    end
  endgenerate

  logic                  dv_q, dv_d;
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;

  logic                  empty, full;
  logic                  push_req, push, pop, ovf_set;
  logic [EW-1:0]         wr_entry, rd_entry;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                 (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  assign wr_entry = {framing_error, parity_error, P_DATA};

  always_comb begin
    dv_d     = data_valid;
    push_req = data_valid & ~dv_q;
    pop      = RD_EN & ~empty;
    // A pop on a full FIFO frees the slot this push lands in.
    push     = push_req & (~full | pop);
    ovf_set  = push_req & full & ~pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    count_d = wr_ptr_d - rd_ptr_d;

    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (CLR_OVF) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dv_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      dv_q     <= dv_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (EW)
  ) u_mem (
    .clk     (CLK),
    .wr_en   (push),
    .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_dat  (wr_entry),
    .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_dat  (rd_entry)
  );

  always_comb begin
    RD_DATA    = '0;
    RD_PAR_ERR = 1'b0;
    RD_FRM_ERR = 1'b0;
    if (!empty) begin
      RD_DATA    = rd_entry[DATA_WIDTH-1:0];
      RD_PAR_ERR = rd_entry[PAR_BIT];
      RD_FRM_ERR = rd_entry[FRM_BIT];
    end
  end

  assign EMPTY    = empty;
  assign FULL     = full;
  assign COUNT    = count_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo; frames are driven as UART_RX would present them.
module tb_uart_rx_fifo;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       data_valid = 1'b0;
  logic       parity_error = 1'b0;
  logic       framing_error = 1'b0;
  logic       RD_EN = 1'b0;
  logic       CLR_OVF = 1'b0;
  logic [7:0] RD_DATA;
  logic       RD_PAR_ERR;
  logic       RD_FRM_ERR;
  logic       EMPTY;
  logic       FULL;
  logic [3:0] COUNT;
  logic       OVERFLOW;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .P_DATA        (P_DATA),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .RD_EN         (RD_EN),
    .CLR_OVF       (CLR_OVF),
    .RD_DATA       (RD_DATA),
    .RD_PAR_ERR    (RD_PAR_ERR),
    .RD_FRM_ERR    (RD_FRM_ERR),
    .EMPTY         (EMPTY),
    .FULL          (FULL),
    .COUNT         (COUNT),
    .OVERFLOW      (OVERFLOW)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b0;
    data_valid = 1'b0;
    RD_EN = 1'b0;
    CLR_OVF = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  // One frame: strobe high for one edge, then low for one edge.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic fe);
    P_DATA = d;
    parity_error = pe;
    framing_error = fe;
    data_valid = 1'b1;
    @(negedge CLK);
    data_valid = 1'b0;
    parity_error = 1'b0;
    framing_error = 1'b0;
    @(negedge CLK);
  endtask

  task automatic pop_one();
    RD_EN = 1'b1;
    @(negedge CLK);
    RD_EN = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_ovf", OVERFLOW, 0);
    chk("rst_rd_data", RD_DATA, 0);

    // Single frame
    send_frame(8'hBB, 1'b0, 1'b0);
    chk("single_empty", EMPTY, 0);
    chk("single_count", COUNT, 1);
    chk("single_data", RD_DATA, 8'hBB);
    chk("single_par", RD_PAR_ERR, 0);
    chk("single_frm", RD_FRM_ERR, 0);
    pop_one();
    chk("single_pop_empty", EMPTY, 1);
    chk("single_pop_data", RD_DATA, 0);
    chk("single_pop_count", COUNT, 0);
    pop_one();
    chk("pop_on_empty_count", COUNT, 0);

    // Held strobe
    do_reset();
    P_DATA = 8'h3C;
    data_valid = 1'b1;
    repeat (5) @(negedge CLK);
    data_valid = 1'b0;
    @(negedge CLK);
    chk("held_count", COUNT, 1);
    chk("held_data", RD_DATA, 8'h3C);

    // Fill and overflow
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      send_frame(i[7:0], 1'b0, 1'b0);
    end
    chk("fill_full", FULL, 1);
    chk("fill_count", COUNT, 8);
    chk("fill_ovf", OVERFLOW, 0);
    send_frame(8'h09, 1'b0, 1'b0);
    chk("ovf_set", OVERFLOW, 1);
    chk("ovf_count", COUNT, 8);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_%0d", i), RD_DATA, i);
      pop_one();
    end
    chk("drain_empty", EMPTY, 1);
    chk("drain_ovf_sticky", OVERFLOW, 1);
    CLR_OVF = 1'b1;
    @(negedge CLK);
    CLR_OVF = 1'b0;
    chk("clr_ovf", OVERFLOW, 0);

    // Error tagging
    do_reset();
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'hAA, 1'b0, 1'b1);
    chk("err0_data", RD_DATA, 8'h55);
    chk("err0_par", RD_PAR_ERR, 1);
    chk("err0_frm", RD_FRM_ERR, 0);
    pop_one();
    chk("err1_data", RD_DATA, 8'hAA);
    chk("err1_par", RD_PAR_ERR, 0);
    chk("err1_frm", RD_FRM_ERR, 1);

    // Simultaneous push and pop while full
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      send_frame(8'h10 + i[7:0], 1'b0, 1'b0);
    end
    P_DATA = 8'h99;
    data_valid = 1'b1;
    RD_EN = 1'b1;
    @(negedge CLK);
    data_valid = 1'b0;
    RD_EN = 1'b0;
    @(negedge CLK);
    chk("pp_full_count", COUNT, 8);
    chk("pp_full_flag", FULL, 1);
    chk("pp_full_ovf", OVERFLOW, 0);
    chk("pp_full_head", RD_DATA, 8'h12);
    repeat (7) pop_one();
    chk("pp_full_tail", RD_DATA, 8'h99);

    // Overflowing push with CLR_OVF in the same cycle: set wins
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      send_frame(i[7:0], 1'b0, 1'b0);
    end
    P_DATA = 8'hEE;
    data_valid = 1'b1;
    CLR_OVF = 1'b1;
    @(negedge CLK);
    data_valid = 1'b0;
    CLR_OVF = 1'b0;
    @(negedge CLK);
    chk("ovf_set_wins", OVERFLOW, 1);

    // Simultaneous push and pop while empty
    do_reset();
    P_DATA = 8'h5A;
    data_valid = 1'b1;
    RD_EN = 1'b1;
    @(negedge CLK);
    data_valid = 1'b0;
    RD_EN = 1'b0;
    @(negedge CLK);
    chk("pp_empty_count", COUNT, 1);
    chk("pp_empty_data", RD_DATA, 8'h5A);

    // Mid-operation reset
    do_reset();
    send_frame(8'h01, 1'b0, 1'b0);
    send_frame(8'h02, 1'b0, 1'b0);
    send_frame(8'h03, 1'b0, 1'b0);
    chk("mid_pre_count", COUNT, 3);
    #1 RST = 1'b0;
    #1;
    chk("mid_rst_empty", EMPTY, 1);
    chk("mid_rst_count", COUNT, 0);
    chk("mid_rst_ovf", OVERFLOW, 0);
    #2 RST = 1'b1;
    @(negedge CLK);
    send_frame(8'h77, 1'b0, 1'b0);
    chk("mid_post_count", COUNT, 1);
    chk("mid_post_data", RD_DATA, 8'h77);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
